// File: rtl/bsg_mul_array_pkg.sv
// Shared types, constants and width helpers for the elastic array-multiplier stage.
package bsg_mul_array_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } bsg_mul_array_state_e;

    localparam int bsg_mul_array_buf_els_gp = 2;

    function automatic int accum_width(input int row_idx, input int rows);
        return row_idx + rows;
    endfunction

    // A zero-width retired-bit input is not legal, so the first stage gets a dummy bit.
    function automatic int accum_in_width(input int row_idx);
        return (row_idx > 0) ? row_idx : 1;
    endfunction

endpackage

// File: rtl/bsg_mul_array_stage_row_comb.sv
// One combinational multiplier row: adds the gated multiplicand to the halved running sum.
// Signed rows sign-extend the partial product and the sum; the final signed row subtracts.
module bsg_mul_array_row_comb #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] a,
    input  logic               b_bit,
    input  logic [width_p-1:0] s,
    input  logic               c,
    input  logic               is_last,
    input  logic               is_signed,
    output logic [width_p-1:0] s_next,
    output logic               c_next
);

    logic [width_p:0] shifted;
    logic [width_p:0] pp;
    logic [width_p:0] sum;

    // s[0] was already retired by the previous row, so only the upper bits carry forward.
    always_comb begin
        shifted = {is_signed & c, c, s[width_p-1:1]};
        pp      = {is_signed & a[width_p-1], a} & {(width_p+1){b_bit}};
        if (is_signed && is_last) begin
            sum = shifted - pp;
        end else begin
            sum = shifted + pp;
        end
        {c_next, s_next} = sum;
    end

endmodule

// File: rtl/bsg_mul_array_stage.sv
// Elastic array-multiplier stage: rows_p combinational rows feeding a 2-entry output FIFO.
// Define BSG_MUL_ARRAY_STAGE_SIGNED_EN to add the signed_i/signed_o two's-complement mode.
module bsg_mul_array_stage
    import bsg_mul_array_pkg::*;
#(
    parameter int width_p   = 16,
    parameter int rows_p    = 1,
    parameter int row_idx_p = 0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        v_i,
    output logic                                        ready_o,
    input  logic [width_p-1:0]                          a_i,
    input  logic [width_p-1:0]                          b_i,
    input  logic [width_p-1:0]                          s_i,
    input  logic                                        c_i,
    input  logic [accum_in_width(row_idx_p)-1:0]        prod_accum_i,
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
    input  logic                                        signed_i,
    output logic                                        signed_o,
`endif
    output logic                                        v_o,
    input  logic                                        yumi_i,
    output logic [width_p-1:0]                          a_o,
    output logic [width_p-1:0]                          b_o,
    output logic [width_p-1:0]                          s_o,
    output logic                                        c_o,
    output logic [accum_width(row_idx_p, rows_p)-1:0]   prod_accum_o
);

    localparam int acc_w = accum_width(row_idx_p, rows_p);

    logic                 enq;
    logic                 deq;
    logic                 sgn_in;
    logic [width_p-1:0]   s_first;
    logic                 c_first;
    logic [width_p-1:0]   s_last;
    logic                 c_last;
    logic [acc_w-1:0]     accum_next;

    assign enq = v_i & ready_o;
    assign deq = v_o & yumi_i;

`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
    assign sgn_in = signed_i;
`else
    assign sgn_in = 1'b0;
`endif

    if (row_idx_p == 0) begin : g_first
        logic accum_unused;
        assign accum_unused = ^{prod_accum_i, s_i, c_i};
        assign s_first = '0;
        assign c_first = 1'b0;
    end else begin : g_mid
        assign s_first = s_i;
        assign c_first = c_i;
        assign accum_next[row_idx_p-1:0] = prod_accum_i;
    end

    // Each row retires its sum LSB as the next product bit above the bits already retired.
    for (genvar k = 0; k < rows_p; k++) begin : g_row
        logic [width_p-1:0] s_in;
        logic [width_p-1:0] s_nx;
        logic               c_in;
        logic               c_nx;

        if (k == 0) begin : g_src
            assign s_in = s_first;
            assign c_in = c_first;
        end else begin : g_src
            assign s_in = g_row[k-1].s_nx;
            assign c_in = g_row[k-1].c_nx;
        end

        bsg_mul_array_row_comb #(
            .width_p (width_p)
        ) row (
            .a         (a_i),
            .b_bit     (b_i[row_idx_p+k]),
            .s         (s_in),
            .c         (c_in),
            .is_last   ((row_idx_p + k) == (width_p - 1)),
            .is_signed (sgn_in),
            .s_next    (s_nx),
            .c_next    (c_nx)
        );

        assign accum_next[row_idx_p+k] = s_nx[0];
    end

    assign s_last = g_row[rows_p-1].s_nx;
    assign c_last = g_row[rows_p-1].c_nx;

    logic [width_p-1:0] a_q   [bsg_mul_array_buf_els_gp];
    logic [width_p-1:0] b_q   [bsg_mul_array_buf_els_gp];
    logic [width_p-1:0] s_q   [bsg_mul_array_buf_els_gp];
    logic               c_q   [bsg_mul_array_buf_els_gp];
    logic [acc_w-1:0]   acc_q [bsg_mul_array_buf_els_gp];
    logic               wr_ptr;
    logic               rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < bsg_mul_array_buf_els_gp; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                s_q[i]   <= '0;
                c_q[i]   <= 1'b0;
                acc_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                a_q[wr_ptr]   <= a_i;
                b_q[wr_ptr]   <= b_i;
                s_q[wr_ptr]   <= s_last;
                c_q[wr_ptr]   <= c_last;
                acc_q[wr_ptr] <= accum_next;
                wr_ptr        <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
    logic sgn_q [bsg_mul_array_buf_els_gp];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < bsg_mul_array_buf_els_gp; i++) begin
                sgn_q[i] <= 1'b0;
            end
        end else if (enq) begin
            sgn_q[wr_ptr] <= signed_i;
        end
    end

    assign signed_o = sgn_q[rd_ptr];
`endif

    assign a_o          = a_q[rd_ptr];
    assign b_o          = b_q[rd_ptr];
    assign s_o          = s_q[rd_ptr];
    assign c_o          = c_q[rd_ptr];
    assign prod_accum_o = acc_q[rd_ptr];

    bsg_mul_array_state_e state;

    // Occupancy FSM; v_o and ready_o are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= EMPTY;
            v_o     <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (enq) begin
                        state <= ONE;
                        v_o   <= 1'b1;
                    end
                end
                ONE: begin
                    if (enq && !deq) begin
                        state   <= FULL;
                        ready_o <= 1'b0;
                    end else if (deq && !enq) begin
                        state <= EMPTY;
                        v_o   <= 1'b0;
                    end
                end
                FULL: begin
                    if (deq) begin
                        state   <= ONE;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    v_o     <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_mul_array_stage.sv
// Self-checking bench: a full 8x8 single stage plus a two-stage 4+4 chain, directed vectors.
`timescale 1ns/1ps
module tb_bsg_mul_array_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    // Full single-stage 8x8 multiplier
    logic       f_v, f_ready, f_vo, f_yumi, f_c, f_sgn_i;
    logic [7:0] f_a, f_b, f_ao, f_bo, f_so, f_acc;
    logic [15:0] f_prod;
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
    logic       f_sgn_o;
`endif
    assign f_prod = {f_c, f_so[7:1], f_acc};

    bsg_mul_array_stage #(.width_p(8), .rows_p(8), .row_idx_p(0)) dut_full (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .v_i          (f_v),
        .ready_o      (f_ready),
        .a_i          (f_a),
        .b_i          (f_b),
        .s_i          (8'h00),
        .c_i          (1'b0),
        .prod_accum_i (1'b0),
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
        .signed_i     (f_sgn_i),
        .signed_o     (f_sgn_o),
`endif
        .v_o          (f_vo),
        .yumi_i       (f_yumi),
        .a_o          (f_ao),
        .b_o          (f_bo),
        .s_o          (f_so),
        .c_o          (f_c),
        .prod_accum_o (f_acc)
    );

    // Two chained 4-row stages
    logic       c0_v, c0_ready, c0_vo, c0_yumi, c0_c, ch_sgn, ch_take;
    logic [7:0] c0_a, c0_b, c0_ao, c0_bo, c0_so;
    logic [3:0] c0_acc;
    logic       c1_ready, c1_vo, c1_yumi, c1_c;
    logic [7:0] c1_ao, c1_bo, c1_so, c1_acc;
    logic [15:0] c1_prod;
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
    logic       c0_sgn_o, c1_sgn_o;
`endif
    assign c0_yumi = c0_vo & c1_ready;
    assign c1_yumi = c1_vo & ch_take;
    assign c1_prod = {c1_c, c1_so[7:1], c1_acc};

    bsg_mul_array_stage #(.width_p(8), .rows_p(4), .row_idx_p(0)) dut_ch0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .v_i          (c0_v),
        .ready_o      (c0_ready),
        .a_i          (c0_a),
        .b_i          (c0_b),
        .s_i          (8'h00),
        .c_i          (1'b0),
        .prod_accum_i (1'b0),
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
        .signed_i     (ch_sgn),
        .signed_o     (c0_sgn_o),
`endif
        .v_o          (c0_vo),
        .yumi_i       (c0_yumi),
        .a_o          (c0_ao),
        .b_o          (c0_bo),
        .s_o          (c0_so),
        .c_o          (c0_c),
        .prod_accum_o (c0_acc)
    );

    bsg_mul_array_stage #(.width_p(8), .rows_p(4), .row_idx_p(4)) dut_ch1 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .v_i          (c0_vo),
        .ready_o      (c1_ready),
        .a_i          (c0_ao),
        .b_i          (c0_bo),
        .s_i          (c0_so),
        .c_i          (c0_c),
        .prod_accum_i (c0_acc),
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
        .signed_i     (c0_sgn_o),
        .signed_o     (c1_sgn_o),
`endif
        .v_o          (c1_vo),
        .yumi_i       (c1_yumi),
        .a_o          (c1_ao),
        .b_o          (c1_bo),
        .s_o          (c1_so),
        .c_o          (c1_c),
        .prod_accum_o (c1_acc)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [15:0] expected;
    } vec_t;

    vec_t vecs[$];
    logic [7:0]  ch_a   [3];
    logic [7:0]  ch_b   [3];
    logic [15:0] ch_exp [3];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, then presents one beat to the full stage for one edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        int guard = 0;
        while (!f_ready && guard < 20) begin
            step();
            guard++;
        end
        checkOutput("ready_wait", 16'(f_ready), 16'd1);
        f_a     = a;
        f_b     = b;
        f_sgn_i = sgn;
        f_v     = 1'b1;
        step();
        f_v = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int got;
        int first_cyc;
        int last_cyc;

        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h00, 8'hA5, 1'b0, 16'h0000});
        vecs.push_back('{8'h01, 8'hFF, 1'b0, 16'h00FF});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});
        vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 16'h3872});
        vecs.push_back('{8'h7F, 8'h81, 1'b0, 16'h3FFF});
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
        vecs.push_back('{8'h80, 8'hFF, 1'b1, 16'h0080});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'h7F, 8'h81, 1'b1, 16'hC0FF});
        vecs.push_back('{8'h03, 8'hFD, 1'b1, 16'hFFF7});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
`endif
        ch_a[0] = 8'h12; ch_b[0] = 8'h34; ch_exp[0] = 16'h03A8;
        ch_a[1] = 8'h03; ch_b[1] = 8'h05; ch_exp[1] = 16'h000F;
        ch_a[2] = 8'h10; ch_b[2] = 8'h10; ch_exp[2] = 16'h0100;

        rst_n = 1'b0;
        f_v = 1'b0; f_yumi = 1'b0; f_a = '0; f_b = '0; f_sgn_i = 1'b0;
        c0_v = 1'b0; c0_a = '0; c0_b = '0; ch_sgn = 1'b0; ch_take = 1'b0;

        #12;
        checkOutput("reset_v_o", 16'(f_vo), 16'd0);
        checkOutput("reset_ready", 16'(f_ready), 16'd1);
        checkOutput("reset_prod", f_prod, 16'h0000);
        checkOutput("reset_chain_v_o", 16'(c1_vo), 16'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn);
            checkOutput("latency_v_o", 16'(f_vo), 16'd1);
            checkOutput($sformatf("prod[%0d]", i), f_prod, vecs[i].expected);
            checkOutput("ab_passthru", {f_ao, f_bo}, {vecs[i].a, vecs[i].b});
`ifdef BSG_MUL_ARRAY_STAGE_SIGNED_EN
            checkOutput("signed_passthru", 16'(f_sgn_o), 16'(vecs[i].sgn));
`endif
            f_yumi = 1'b1;
            step();
            f_yumi = 1'b0;
            checkOutput("drained_v_o", 16'(f_vo), 16'd0);
        end

        // Backpressure: two beats absorbed, third held off until one is taken.
        applyStimulus(8'h03, 8'h05, 1'b0);
        applyStimulus(8'h10, 8'h10, 1'b0);
        checkOutput("full_ready", 16'(f_ready), 16'd0);
        checkOutput("full_head", f_prod, 16'h000F);
        f_a = 8'h12; f_b = 8'h34; f_v = 1'b1;
        step();
        checkOutput("held_ready", 16'(f_ready), 16'd0);
        checkOutput("held_stable", f_prod, 16'h000F);
        f_yumi = 1'b1;
        step();
        f_yumi = 1'b0;
        checkOutput("ready_after_deq", 16'(f_ready), 16'd1);
        checkOutput("second_beat", f_prod, 16'h0100);
        step();
        f_v = 1'b0;
        checkOutput("refull_ready", 16'(f_ready), 16'd0);
        checkOutput("refull_head", f_prod, 16'h0100);
        f_yumi = 1'b1;
        step();
        checkOutput("third_beat", f_prod, 16'h03A8);
        // Simultaneous enq and deq while holding one entry.
        f_a = 8'hFF; f_b = 8'hFF; f_v = 1'b1;
        step();
        f_v = 1'b0;
        checkOutput("one_enqdeq_v_o", 16'(f_vo), 16'd1);
        checkOutput("one_enqdeq_ready", 16'(f_ready), 16'd1);
        checkOutput("one_enqdeq_prod", f_prod, 16'hFE01);
        step();
        f_yumi = 1'b0;
        checkOutput("one_drain_v_o", 16'(f_vo), 16'd0);

        // Asynchronous reset while full.
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        applyStimulus(8'h12, 8'h34, 1'b0);
        checkOutput("prereset_ready", 16'(f_ready), 16'd0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_v_o", 16'(f_vo), 16'd0);
        checkOutput("async_rst_ready", 16'(f_ready), 16'd1);
        checkOutput("async_rst_prod", f_prod, 16'h0000);
        checkOutput("async_rst_ab", {f_ao, f_bo}, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(8'hAA, 8'h55, 1'b0);
        checkOutput("post_rst_v_o", 16'(f_vo), 16'd1);
        checkOutput("post_rst_prod", f_prod, 16'h3872);
        f_yumi = 1'b1;
        step();
        f_yumi = 1'b0;

        // Chain: three back-to-back beats, consumer always taking.
        ch_take   = 1'b1;
        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (c1_vo) begin
                if (got < 3) begin
                    checkOutput($sformatf("chain_prod[%0d]", got), c1_prod, ch_exp[got]);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (cyc < 3) begin
                checkOutput("chain_ready", 16'(c0_ready), 16'd1);
                c0_a = ch_a[cyc];
                c0_b = ch_b[cyc];
                c0_v = 1'b1;
            end else begin
                c0_v = 1'b0;
            end
            step();
        end
        checkOutput("chain_count", 16'(got), 16'd3);
        checkOutput("chain_first_latency", 16'(first_cyc), 16'd2);
        checkOutput("chain_throughput", 16'(last_cyc - first_cyc), 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
